// File: rtl/fifo_command_gen2_pkg.sv
// Shared sizing helpers for the command/data/response FIFO family.
package fifo_command_gen2_pkg;

    function automatic int fifo_depth(input int adbus);
        return 1 << adbus;
    endfunction

    // Level must reach DEPTH, so it needs one bit more than an address.
    function automatic int level_width(input int adbus);
        return adbus + 1;
    endfunction

endpackage

// File: rtl/fifo_command_gen2_if.sv
// Producer/consumer bundle of the command FIFO.
interface fifo_command_gen2_if #(
    parameter int DATA  = 8,
    parameter int ADBUS = 3
);
    logic             flush;
    logic             clr_err;
    logic             wr_en;
    logic [DATA-1:0]  Data_in;
    logic             rd_en;
    logic [DATA-1:0]  Data_out;
    logic             Rd_valid;
    logic             In_Busy;
    logic             Out_Busy;
    logic             Almost_full;
    logic             Almost_empty;
    logic [ADBUS:0]   Level;
    logic             Overflow;
    logic             Underflow;

    modport master (
        output flush, clr_err, wr_en, Data_in, rd_en,
        input  Data_out, Rd_valid, In_Busy, Out_Busy,
        input  Almost_full, Almost_empty, Level,
        input  Overflow, Underflow
    );

    modport slave (
        input  flush, clr_err, wr_en, Data_in, rd_en,
        output Data_out, Rd_valid, In_Busy, Out_Busy,
        output Almost_full, Almost_empty, Level,
        output Overflow, Underflow
    );
endinterface

// File: rtl/fifo_command_gen2_ram.sv
// DEPTH x DATA register array: one sync write port,
// one enable-gated registered read port.
module fifo_command_ram #(
    parameter int DATA  = 8,
    parameter int ADBUS = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we_i,
    input  logic [ADBUS-1:0] waddr_i,
    input  logic [DATA-1:0]  wdata_i,
    input  logic             re_i,
    input  logic [ADBUS-1:0] raddr_i,
    output logic [DATA-1:0]  rdata_o
);
    logic [DATA-1:0] mem_q [2**ADBUS];
    logic [DATA-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    // Same-slot read+write (full case) returns the old word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       rdata_q <= '0;
        else if (re_i) rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/fifo_command_gen2.sv
// Parametrised command FIFO between sequencer and multiplier;
// pointer + level counter control, storage in fifo_command_ram.
module fifo_command_gen2
    import fifo_command_gen2_pkg::*;
#(
    parameter int DATA      = 8,
    parameter int ADBUS     = 3,
    parameter int AFULL_TH  = 6,
    parameter int AEMPTY_TH = 1
) (
    input  logic clk,
    input  logic rst,
    fifo_command_gen2_if.slave bus
);
    localparam int DEPTH = fifo_depth(ADBUS);
    localparam int LW    = level_width(ADBUS);
    localparam logic [ADBUS-1:0] A_ONE = 1;
    localparam logic [LW-1:0]    L_ONE = 1;

    logic [ADBUS-1:0] wr_addr_q, wr_addr_d;
    logic [ADBUS-1:0] rd_addr_q, rd_addr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             rd_valid_q, rd_valid_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             full, empty;
    logic             rd_acc, wr_acc;
    logic             ovf_set, unf_set;

    assign full  = (level_q == LW'(DEPTH));
    assign empty = (level_q == '0);

    // A read frees the slot, so a full FIFO still accepts wr+rd.
    assign rd_acc  = bus.rd_en & ~empty & ~bus.flush;
    assign wr_acc  = bus.wr_en & (~full | rd_acc) & ~bus.flush;
    assign ovf_set = bus.wr_en & ~wr_acc & ~bus.flush;
    assign unf_set = bus.rd_en & empty & ~bus.flush;

    always_comb begin
        wr_addr_d  = wr_addr_q;
        rd_addr_d  = rd_addr_q;
        level_d    = level_q;
        rd_valid_d = rd_acc;
        if (bus.flush) begin
            wr_addr_d = '0;
            rd_addr_d = '0;
            level_d   = '0;
        end else begin
            if (wr_acc) wr_addr_d = wr_addr_q + A_ONE;
            if (rd_acc) rd_addr_d = rd_addr_q + A_ONE;
            if (wr_acc && !rd_acc) level_d = level_q + L_ONE;
            if (rd_acc && !wr_acc) level_d = level_q - L_ONE;
        end
    end

    always_comb begin
        ovf_d = ovf_q;
        unf_d = unf_q;
        if (bus.clr_err) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end
        if (ovf_set) ovf_d = 1'b1;
        if (unf_set) unf_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_addr_q  <= '0;
            rd_addr_q  <= '0;
            level_q    <= '0;
            rd_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            wr_addr_q  <= wr_addr_d;
            rd_addr_q  <= rd_addr_d;
            level_q    <= level_d;
            rd_valid_q <= rd_valid_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
        end
    end

    fifo_command_ram #(
        .DATA  (DATA),
        .ADBUS (ADBUS)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .we_i    (wr_acc),
        .waddr_i (wr_addr_q),
        .wdata_i (bus.Data_in),
        .re_i    (rd_acc),
        .raddr_i (rd_addr_q),
        .rdata_o (bus.Data_out)
    );

    assign bus.Rd_valid     = rd_valid_q;
    assign bus.In_Busy      = full;
    assign bus.Out_Busy     = empty;
    assign bus.Almost_full  = (level_q >= LW'(AFULL_TH));
    assign bus.Almost_empty = (level_q <= LW'(AEMPTY_TH));
    assign bus.Level        = level_q;
    assign bus.Overflow     = ovf_q;
    assign bus.Underflow    = unf_q;
endmodule

// File: tb/tb_fifo_command_gen2.sv
// Bench for fifo_command_gen2: 8-deep and 16-deep instances driven
// in parallel, one selected for checking against a queue model.
module tb_fifo_command_gen2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       wr = 0, rd = 0, fl = 0, ce = 0;
    logic [7:0] din = 0;
    bit         sel = 0;

    fifo_command_gen2_if #(.DATA(8), .ADBUS(3)) b8 ();
    fifo_command_gen2_if #(.DATA(8), .ADBUS(4)) b16 ();

    assign b8.wr_en   = wr;
    assign b8.rd_en   = rd;
    assign b8.flush   = fl;
    assign b8.clr_err = ce;
    assign b8.Data_in = din;
    assign b16.wr_en   = wr;
    assign b16.rd_en   = rd;
    assign b16.flush   = fl;
    assign b16.clr_err = ce;
    assign b16.Data_in = din;

    fifo_command_gen2 #(
        .DATA(8), .ADBUS(3), .AFULL_TH(6), .AEMPTY_TH(1)
    ) dut8 (.clk(clk), .rst(rst), .bus(b8));

    fifo_command_gen2 #(
        .DATA(8), .ADBUS(4), .AFULL_TH(12), .AEMPTY_TH(1)
    ) dut16 (.clk(clk), .rst(rst), .bus(b16));

    logic [7:0] o_dout;
    logic [4:0] o_lvl;
    logic [6:0] o_flg;
    assign o_dout = sel ? b16.Data_out : b8.Data_out;
    assign o_lvl  = sel ? b16.Level : {1'b0, b8.Level};
    assign o_flg  = sel ?
        {b16.Rd_valid, b16.In_Busy, b16.Out_Busy, b16.Almost_full,
         b16.Almost_empty, b16.Overflow, b16.Underflow} :
        {b8.Rd_valid, b8.In_Busy, b8.Out_Busy, b8.Almost_full,
         b8.Almost_empty, b8.Overflow, b8.Underflow};

    int err = 0;
    int chk = 0;

    // Reference model: a queue of words plus the visible registers.
    logic [7:0] q[$];
    logic [7:0] m_dout;
    bit m_rv, m_ovf, m_unf;
    int D = 8, AFT = 6, AET = 1;

    function automatic logic [6:0] m_flg();
        int sz = q.size();
        return {m_rv, sz == D, sz == 0, sz >= AFT, sz <= AET,
                m_ovf, m_unf};
    endfunction

    task automatic model_clear();
        q.delete();
        m_dout = 0;
        m_rv = 0;
        m_ovf = 0;
        m_unf = 0;
    endtask

    task automatic model_step(input bit w, input logic [7:0] d,
                              input bit r, input bit f, input bit c);
        int sz = q.size();
        bit cr, cw, so, su;
        so = 0;
        su = 0;
        if (f) begin
            q.delete();
            m_rv = 0;
        end else begin
            cr = r && sz > 0;
            cw = w && (sz < D || cr);
            su = r && sz == 0;
            so = w && !cw;
            if (cr) m_dout = q.pop_front();
            m_rv = cr;
            if (cw) q.push_back(d);
        end
        if (c) begin
            m_ovf = 0;
            m_unf = 0;
        end
        if (so) m_ovf = 1;
        if (su) m_unf = 1;
    endtask

    task automatic step(input bit w, input logic [7:0] d, input bit r,
                        input bit f = 0, input bit c = 0);
        wr = w; din = d; rd = r; fl = f; ce = c;
        @(posedge clk);
        model_step(w, d, r, f, c);
        #1;
        wr = 0; rd = 0; fl = 0; ce = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        model_clear();
        @(posedge clk);
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        chk++;
        if (o_lvl !== 5'd0) begin
            err++;
            $display("FAIL reset_level got=%0d exp=0", o_lvl);
        end
        chk++;
        if (o_flg !== 7'b0010100) begin
            err++;
            $display("FAIL reset_flags got=%b exp=0010100", o_flg);
        end
        chk++;
        if (o_dout !== 8'h00) begin
            err++;
            $display("FAIL reset_dout got=%h exp=00", o_dout);
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < D; i++) begin
            step(1, 8'(i + 1), 0);
            chk++;
            if (o_lvl !== 5'(i + 1)) begin
                err++;
                $display("FAIL fill_level i=%0d got=%0d exp=%0d",
                         i, o_lvl, i + 1);
            end
            chk++;
            if (o_flg !== m_flg()) begin
                err++;
                $display("FAIL fill_flags i=%0d got=%b exp=%b",
                         i, o_flg, m_flg());
            end
        end
        step(1, 8'hFF, 0);
        chk++;
        if (o_lvl !== 5'(D) || o_flg[1] !== 1'b1 || o_flg[5] !== 1'b1) begin
            err++;
            $display("FAIL fill_overflow lvl=%0d flg=%b exp lvl=%0d ovf=1",
                     o_lvl, o_flg, D);
        end
    endtask

    task automatic test_drain();
        for (int i = 0; i < D; i++) begin
            step(0, 0, 1);
            chk++;
            if (o_dout !== 8'(i + 1) || o_flg[6] !== 1'b1) begin
                err++;
                $display("FAIL drain i=%0d dout=%h rv=%b exp=%h rv=1",
                         i, o_dout, o_flg[6], 8'(i + 1));
            end
            chk++;
            if (o_flg !== m_flg()) begin
                err++;
                $display("FAIL drain_flags i=%0d got=%b exp=%b",
                         i, o_flg, m_flg());
            end
        end
        step(0, 0, 1);
        chk++;
        if (o_dout !== 8'(D) || o_flg[0] !== 1'b1 || o_flg[6] !== 1'b0) begin
            err++;
            $display("FAIL underflow dout=%h flg=%b exp dout=%h unf=1 rv=0",
                     o_dout, o_flg, 8'(D));
        end
    endtask

    task automatic test_full_rw();
        step(0, 0, 0, 0, 1);
        for (int i = 0; i < D; i++) step(1, 8'(i + 1), 0);
        step(1, 8'hAA, 1);
        chk++;
        if (o_dout !== 8'h01 || o_lvl !== 5'(D) || o_flg[1:0] !== 2'b00) begin
            err++;
            $display("FAIL full_rw dout=%h lvl=%0d flg=%b exp 01 %0d err=00",
                     o_dout, o_lvl, o_flg, D);
        end
        for (int i = 0; i < D; i++) begin
            logic [7:0] e;
            e = (i == D - 1) ? 8'hAA : 8'(i + 2);
            step(0, 0, 1);
            chk++;
            if (o_dout !== e || o_dout !== m_dout) begin
                err++;
                $display("FAIL full_rw_drain i=%0d got=%h exp=%h",
                         i, o_dout, e);
            end
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 20; i++) begin
            step(1, 8'(8'h10 + i), 0);
            chk++;
            if (o_lvl !== 5'd1) begin
                err++;
                $display("FAIL wrap_lvl1 i=%0d got=%0d exp=1", i, o_lvl);
            end
            step(0, 0, 1);
            chk++;
            if (o_dout !== 8'(8'h10 + i) || o_lvl !== 5'd0 ||
                o_flg[1:0] !== 2'b00) begin
                err++;
                $display("FAIL wrap i=%0d dout=%h lvl=%0d flg=%b exp=%h",
                         i, o_dout, o_lvl, o_flg, 8'(8'h10 + i));
            end
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 5; i++) step(1, 8'(8'h30 + i), 0);
        step(1, 8'h55, 0, 1);
        chk++;
        if (o_lvl !== 5'd0 || o_flg[4] !== 1'b1 || o_flg[6] !== 1'b0) begin
            err++;
            $display("FAIL flush lvl=%0d flg=%b exp lvl=0 empty=1",
                     o_lvl, o_flg);
        end
        step(0, 0, 1);
        chk++;
        if (o_flg !== m_flg() || o_dout !== m_dout) begin
            err++;
            $display("FAIL flush_dropped flg=%b dout=%h exp flg=%b dout=%h",
                     o_flg, o_dout, m_flg(), m_dout);
        end
        step(0, 0, 0, 0, 1);
        chk++;
        if (o_flg[1:0] !== 2'b00) begin
            err++;
            $display("FAIL clr_err got=%b exp=00", o_flg[1:0]);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 5; i++) step(1, 8'(8'h60 + i), 0);
        step(0, 0, 1);
        rd = 1;
        #2;
        rst = 1;
        #1;
        chk++;
        if (o_lvl !== 5'd0 || o_flg[6] !== 1'b0 || o_dout !== 8'h00) begin
            err++;
            $display("FAIL async_rst lvl=%0d rv=%b dout=%h exp 0 0 00",
                     o_lvl, o_flg[6], o_dout);
        end
        rd = 0;
        do_reset();
    endtask

    task automatic test_random(input int n);
        for (int i = 0; i < n; i++) begin
            step($urandom_range(0, 99) < 55, 8'($urandom),
                 $urandom_range(0, 99) < 45,
                 $urandom_range(0, 39) == 0,
                 $urandom_range(0, 19) == 0);
            chk++;
            if (o_lvl !== 5'(q.size()) || o_flg !== m_flg() ||
                o_dout !== m_dout) begin
                err++;
                $display("FAIL rand i=%0d lvl=%0d flg=%b dout=%h exp %0d %b %h",
                         i, o_lvl, o_flg, o_dout, q.size(), m_flg(), m_dout);
            end
        end
    endtask

    initial begin
        sel = 0; D = 8; AFT = 6; AET = 1;
        test_reset();
        test_fill();
        test_drain();
        test_full_rw();
        test_wrap();
        test_flush();
        test_async_reset();
        test_random(400);

        sel = 1; D = 16; AFT = 12; AET = 1;
        test_reset();
        test_fill();
        test_drain();
        test_full_rw();
        test_random(400);

        $display("Result: errors=%0d of %0d checks", err, chk);
        $finish;
    end

endmodule
